// File: rtl/data_sram_ctrl.sv
// Data-memory access controller: one EX load/store -> SRAM addr/data handshake, with flush drain.
// Optional misaligned-access trap enabled by defining DATA_SRAM_ALIGN_CHECK_EN.
module data_sram_ctrl #(
   parameter int ALIGN_ADDR = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stallreq,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        addr_err,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t      state;
   logic        discard;
   logic        lat_wr;
   logic [3:0]  lat_wstrb;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic [3:0]  cur_wstrb;
   logic [31:0] cur_wdata;
   logic [31:0] out_addr;
   logic        misaligned;
   logic        issue;

   always_comb begin
      cur_wstrb = 4'b0000;
      cur_wdata = req_wdata;
      case (req_size)
         2'd0: begin
            cur_wstrb = req_we ? (4'b0001 << req_addr[1:0]) : 4'b0000;
            cur_wdata = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            cur_wstrb = req_we ? (4'b0011 << {req_addr[1], 1'b0}) : 4'b0000;
            cur_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            cur_wstrb = req_we ? 4'b1111 : 4'b0000;
            cur_wdata = req_wdata;
         end
      endcase
   end

`ifdef DATA_SRAM_ALIGN_CHECK_EN
   assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                       (req_size[1] && (req_addr[1:0] != 2'b00));
   assign addr_err   = (state == IDLE) && req_valid && !flush && misaligned;
`else
   assign misaligned = 1'b0;
   assign addr_err   = 1'b0;
`endif

   // Only IDLE issues straight from the pipeline; later states replay the latched copy.
   assign issue           = (state == IDLE) && req_valid && !flush && !misaligned;
   assign data_sram_req   = issue || (state == ADDR);
   assign stallreq        = issue || (state == ADDR) || (state == DATA);
   assign data_sram_wr    = (state == IDLE) ? req_we    : lat_wr;
   assign data_sram_wstrb = (state == IDLE) ? cur_wstrb : lat_wstrb;
   assign data_sram_wdata = (state == IDLE) ? cur_wdata : lat_wdata;
   assign out_addr        = (state == IDLE) ? req_addr  : lat_addr;
   assign data_sram_addr  = (ALIGN_ADDR != 0) ? {out_addr[31:2], 2'b00} : out_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         discard     <= 1'b0;
         rdata       <= 32'h0;
         rdata_valid <= 1'b0;
         lat_wr      <= 1'b0;
         lat_wstrb   <= 4'h0;
         lat_addr    <= 32'h0;
         lat_wdata   <= 32'h0;
      end else begin
         rdata_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (issue) begin
                  lat_wr    <= req_we;
                  lat_wstrb <= cur_wstrb;
                  lat_addr  <= req_addr;
                  lat_wdata <= cur_wdata;
                  discard   <= 1'b0;
                  state     <= data_sram_addr_ok ? DATA : ADDR;
               end
            end
            ADDR: begin
               if (flush) discard <= 1'b0 | 1'b1;
               if (data_sram_addr_ok) state <= DATA;
            end
            DATA: begin
               // A flush coinciding with data_ok still suppresses the report.
               if (data_sram_data_ok) begin
                  if (discard || flush) begin
                     discard <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     if (!lat_wr) rdata <= data_sram_rdata;
                     rdata_valid <= 1'b1;
                     state       <= DONE;
                  end
               end else if (flush) begin
                  discard <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Scoreboard bench for data_sram_ctrl: expected SRAM requests and read words are queued
// by the stimulus and popped by independent negedge monitors.
module tb_data_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stallreq;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        addr_err;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   int checks = 0;
   int failures = 0;

   logic [68:0] exp_req_q[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] model_rdata;

   always #5 clk = ~clk;

   data_sram_ctrl #(.ALIGN_ADDR(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stallreq(stallreq), .rdata(rdata), .rdata_valid(rdata_valid), .addr_err(addr_err),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
      .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata)
   );

   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Request monitor: fields must match the expected entry every cycle req is high.
   always @(negedge clk) begin
      if (!rst && data_sram_req) begin
         if (exp_req_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req actual=%h required=none", data_sram_addr);
         end else begin
            check("req_fields", {data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata},
                  exp_req_q[0]);
            if (data_sram_addr_ok) exp_req_q.delete(0);
         end
      end
   end

   // Read-data monitor.
   always @(negedge clk) begin
      if (!rst && rdata_valid) begin
         if (exp_rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid actual=%h required=none", rdata);
         end else begin
            check("rdata", {37'h0, rdata}, {37'h0, exp_rd_q.pop_front()});
         end
      end
   end

   task automatic idle_inputs();
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
      flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
   endtask

   task automatic access(input string name, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int adly, input int ddly, input logic [31:0] resp,
                         input logic do_flush, input logic [3:0] exp_strb,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input int exp_stalls);
      int last;
      int stalls;
      logic rv_seen;
      last = adly + ddly + 2;
      stalls = 0;
      rv_seen = 1'b0;
      exp_req_q.push_back({we, exp_strb, exp_addr, exp_wdata});
      if (!do_flush) begin
         if (!we) model_rdata = resp;
         exp_rd_q.push_back(model_rdata);
      end
      req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
      for (int c = 0; c <= last; c++) begin
         data_sram_addr_ok = (c == adly);
         data_sram_data_ok = (c == adly + 1 + ddly);
         data_sram_rdata   = data_sram_data_ok ? resp : $urandom;
         flush = do_flush && (c == adly + 1);
         if (do_flush && c == last) req_valid = 1'b0;
         @(negedge clk);
         if (stallreq) stalls++;
         if (c == last) rv_seen = rdata_valid;
         @(posedge clk);
         #1;
      end
      idle_inputs();
      check({name, "_stalls"}, 69'(stalls), 69'(exp_stalls));
      check({name, "_rvalid"}, {68'h0, rv_seen}, {68'h0, !do_flush});
      if (do_flush) check({name, "_rdata_kept"}, {37'h0, rdata}, {37'h0, model_rdata});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      model_rdata = 32'h0;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stallreq", {68'h0, stallreq}, 69'h0);
      check("rst_rdata", {37'h0, rdata}, 69'h0);
      check("rst_rvalid", {68'h0, rdata_valid}, 69'h0);
      check("rst_addr_err", {68'h0, addr_err}, 69'h0);
      check("rst_req", {68'h0, data_sram_req}, 69'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      //     name        we size addr          wdata        ad dd resp          fl strb     exp_addr      exp_wdata     stalls
      access("ld_word", 0, 2, 32'h0000_0100, 32'h0,        0, 0, 32'hDEADBEEF, 0, 4'b0000, 32'h0000_0100, 32'h0,        2);
      access("st_byte", 1, 0, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0,       0, 4'b1000, 32'h0000_0200, 32'hA5A5A5A5, 2);
      access("st_half", 1, 1, 32'h0000_0006, 32'h0000_1234, 1, 0, 32'h0,       0, 4'b1100, 32'h0000_0004, 32'h12341234, 3);
      access("ld_slow", 0, 2, 32'h0000_0300, 32'h0,        3, 1, 32'hCAFEF00D, 0, 4'b0000, 32'h0000_0300, 32'h0,        6);
      access("ld_flush",0, 2, 32'h0000_0400, 32'h0,        0, 1, 32'h12345678, 1, 4'b0000, 32'h0000_0400, 32'h0,        3);
      access("ld_after",0, 2, 32'h0000_0404, 32'h0,        0, 0, 32'h0BADF00D, 0, 4'b0000, 32'h0000_0404, 32'h0,        2);
      access("st_word", 1, 3, 32'h0000_0010, 32'h89ABCDEF, 2, 0, 32'h0,       0, 4'b1111, 32'h0000_0010, 32'h89ABCDEF, 4);
      access("ld_byte", 0, 0, 32'h0000_0001, 32'h0,        0, 0, 32'h00000077, 0, 4'b0000, 32'h0000_0000, 32'h0,        2);

`ifdef DATA_SRAM_ALIGN_CHECK_EN
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0102;
      @(negedge clk);
      check("mis_addr_err", {68'h0, addr_err}, 69'h1);
      check("mis_req", {68'h0, data_sram_req}, 69'h0);
      check("mis_stall", {68'h0, stallreq}, 69'h0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("mis_err_pulse", {68'h0, addr_err}, 69'h0);
      @(posedge clk); #1;
`else
      access("ld_mis",  0, 2, 32'h0000_0102, 32'h0,        0, 0, 32'h55AA55AA, 0, 4'b0000, 32'h0000_0100, 32'h0,        2);
      check("mis_addr_err", {68'h0, addr_err}, 69'h0);
`endif

      // Reset while waiting in ADDR.
      exp_req_q.push_back({1'b0, 4'b0000, 32'h0000_0500, 32'h0});
      req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0500;
      @(posedge clk); #1;
      @(negedge clk);
      check("addr_hold_stall", {68'h0, stallreq}, 69'h1);
      @(posedge clk); #1;
      rst = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_0000;
      @(negedge clk);
      check("rstmid_req", {68'h0, data_sram_req}, 69'h0);
      check("rstmid_stall", {68'h0, stallreq}, 69'h0);
      check("rstmid_rdata", {37'h0, rdata}, 69'h0);
      check("rstmid_rvalid", {68'h0, rdata_valid}, 69'h0);
      check("rstmid_addr_err", {68'h0, addr_err}, 69'h0);
      @(posedge clk); #1;
      idle_inputs();
      if (exp_req_q.size() != 0) exp_req_q.delete(0);
      model_rdata = 32'h0;
      @(posedge clk); #1;

      access("ld_post", 0, 2, 32'h0000_0600, 32'h0,        1, 1, 32'h600DCAFE, 0, 4'b0000, 32'h0000_0600, 32'h0,        4);

      repeat (2) @(posedge clk);
      check("req_q_empty", 69'(exp_req_q.size()), 69'h0);
      check("rd_q_empty", 69'(exp_rd_q.size()), 69'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_sram_ctrl.md
# data_sram_ctrl

Data-memory access controller between the EX/MEM pipeline stages and a variable-latency SRAM-like data port. It converts one pipeline load/store into an address/data handshake, generates byte strobes and replicated write data, and raises a stall request until the access completes. It returns the raw 32-bit read word to MEM, which performs the byte and halfword extraction. It also drains in-flight accesses cleanly across a pipeline flush.

## Interface
Parameters:
- ALIGN_ADDR, default 1: when 1, data_sram_addr[1:0] is driven 2'b00; when 0, the full address is passed through.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; the current or pending access must not be reported
- req_valid  in  1  EX holds a load or store; held stable while stallreq=1
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- stallreq  out  1  stall request to the pipeline controller
- rdata  out  32  registered raw read word
- rdata_valid  out  1  rdata is valid this cycle
- addr_err  out  1  misaligned-access pulse; tied 0 unless the Configuration macro is defined
- data_sram_req  out  1
- data_sram_wr  out  1
- data_sram_wstrb  out  4
- data_sram_addr  out  32
- data_sram_wdata  out  32
- data_sram_addr_ok  in  1
- data_sram_data_ok  in  1
- data_sram_rdata  in  32

## Operation
States: IDLE, ADDR, DATA, DONE. One internal discard flag.

IDLE:
- data_sram_req = req_valid & ~flush. The request fields are driven combinationally from req_*.
- If addr_ok is high, go to DATA; otherwise latch the request fields and go to ADDR.
- stallreq = req_valid & ~flush.

ADDR:
- data_sram_req = 1 with the latched fields; hold until addr_ok, then go to DATA.
- A flush in ADDR sets discard. The request is never withdrawn.

DATA:
- data_sram_req = 0.
- A flush sets discard.
- On data_ok: if discard, clear discard and go to IDLE. Otherwise capture data_sram_rdata into rdata (stores capture nothing) and go to DONE.

DONE:
- rdata_valid = 1, stallreq = 0; the pipeline advances this cycle.
- Next state is always IDLE. A new request is not issued from DONE.

stallreq = 1 in ADDR and in DATA, including while discarding.

Strobe and data generation:
- Loads: wstrb = 4'b0000.
- Byte store: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- Half store: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
- Word store: wstrb = 4'b1111; wdata unchanged.
- data_sram_wr = req_we.

Reset values: state IDLE, discard 0, rdata 0, rdata_valid 0, stallreq 0, addr_err 0, data_sram_req 0.

## Timing
- Minimum load latency is 3 cycles from the IDLE issue: addr_ok in cycle 0, data_ok no earlier than cycle 1, rdata_valid in cycle 2.
- Each additional cycle of addr_ok or data_ok delay adds one cycle of stallreq.
- data_ok arriving in the same cycle as addr_ok is illegal and is not checked.
- Throughput is at most one access per 3 cycles; the controller never has more than one outstanding access.
- Flush in IDLE or DONE has no effect beyond suppressing the IDLE issue in that cycle.
- rst mid-access returns to IDLE immediately. Any in-flight SRAM response is ignored only because data_ok outside DATA is ignored.

## Configuration
Macro: DATA_SRAM_ALIGN_CHECK_EN.
- Defined: in IDLE, a half access with addr[0]=1 or a word access with addr[1:0]≠0 issues no SRAM request. addr_err pulses for 1 cycle, stallreq=0, and the state stays IDLE.
- Undefined: no check is made. Half accesses use addr[1] only, word accesses ignore addr[1:0], and addr_err is constant 0.

## Test plan
- Load word at 0x100, addr_ok same cycle, data_ok 1 cycle later with 0xDEADBEEF -> stallreq high for 2 cycles, rdata=0xDEADBEEF with rdata_valid in cycle 2.
- Byte store 0xA5 at 0x203 -> wstrb=4'b1000, wdata=0xA5A5A5A5, wr=1, rdata_valid pulses once.
- addr_ok delayed 3 cycles, data_ok delayed 2 more -> req held with stable addr and wstrb throughout, stallreq high for 6 cycles.
- Flush in DATA, then data_ok with 0x12345678 -> no rdata_valid, rdata unchanged, IDLE next cycle, next request issued normally.
- With the macro defined, word load at 0x102 -> addr_err=1 for 1 cycle, data_sram_req never asserted. Without the macro, the same load issues the request with wstrb=0.
- rst asserted in ADDR -> next cycle all outputs are at their reset values and data_sram_req=0.
